elastic_read_pointer_control: RTL and testbench
===============================================

// Module: elastic_read_pointer_control
// PURPOSE
//  Read-side half of the RX elastic buffer; the write-side pointer control feeds it.
//  Runs in the recovered/local read clock domain.
//  Synchronises the write side's gray write pointer and computes occupancy.
//  Advances the read address, registers the symbol read from buffer memory, and
//  inserts SKP symbols (holds the pointer) when occupancy is low; reports underflow.
// PARAMETERS
//  DATA_WIDTH     10  symbol width (8b/10b code group)
//  BUFFER_DEPTH   16  buffer entries, power of 2; A = $clog2(BUFFER_DEPTH)
//  LOW_WATERMARK  4   occupancy below which an SKP is repeated
//  SYNC_STAGES    2   flops in the gray write pointer synchroniser (>=2)
// PORTS
//  read_clk            in   1        read-domain clock (single clock of this block)
//  rst                 in   1        synchronous, active-high reset
//  gray_write_pointer  in   A+1      gray write pointer from write domain (async)
//  data_in             in   DATA_W   buffer memory read data at read_address (comb. read)
//  read_address        out  A+1      binary read pointer; MSB is the wrap bit
//  gray_read_pointer   out  A+1      binToGray(read_address), combinational
//  data_out            out  DATA_W   registered output symbol
//  data_valid          out  1        data_out carries a valid symbol
//  underflow           out  1        one-cycle pulse: buffer found empty while running
//  Skp_Added           out  1        one-cycle pulse: SKP repeated this cycle
// BEHAVIOUR
//  Reset (rst=1 at posedge): read_address=0, synchroniser flops=0, data_out=0,
//    data_valid=0, underflow=0, Skp_Added=0, skp_held=0, state=FILL.
//    Reset mid-operation discards all in-flight state identically.
//  Sync: gray_write_pointer -> SYNC_STAGES flops -> gray2bin -> wr_bin_s.
//  occ = (wr_bin_s - read_address) mod 2^(A+1); (A+1)-bit unsigned.
//    Lags the true write pointer by SYNC_STAGES cycles, so it is conservative.
//  SKP: data_in == 10'b001111_1001 or 10'b110000_0110.
//  FSM: two states, FILL and RUN.
//   FILL: data_valid<=0, Skp_Added<=0, read_address held.
//     Go to RUN when occ >= BUFFER_DEPTH/2.
//   RUN, occ==0: underflow<=1 (one cycle), data_valid<=0, pointer held, go to FILL.
//   RUN, occ>0: data_out<=data_in, data_valid<=1.
//     Insert case, when data_in is SKP && occ<LOW_WATERMARK && !skp_held:
//       read_address held, Skp_Added<=1, skp_held<=1.
//       The same SKP is therefore output twice in consecutive cycles.
//     Otherwise: read_address<=read_address+1, Skp_Added<=0, skp_held<=0.
//   Insertions are limited to one per SKP symbol position (skp_held).
//   underflow is 0 except in the single cycle after empty detection.
//  Latency: data_out/data_valid update one read_clk after read_address is presented.
//  Wrap: read_address increments modulo 2^(A+1); the MSB toggles every BUFFER_DEPTH
//    reads. occ arithmetic stays correct across the wrap.
//  Full condition is owned by the write side; this block never stalls the writer.
// TESTING
//  1 Reset, write side fills 8 entries -> after SYNC_STAGES+1 cycles, RUN is entered;
//    data_valid=1 the next cycle; data_out follows memory order.
//  2 Steady stream, equal clock rates, occ~8 -> no Skp_Added, no underflow.
//    20 symbols are output in order with one per cycle.
//  3 occ=3, SKP 10'b001111_1001 at read_address -> SKP output twice.
//    Skp_Added=1 for exactly one cycle; read_address advances one cycle late.
//  4 occ=6 with SKP at head -> no insertion; Skp_Added stays 0.
//  5 Writer stops -> occ reaches 0 -> underflow pulse for 1 cycle, data_valid=0.
//    FSM re-enters FILL; output resumes once occ>=8.
//  6 Run 40 symbols (>2*DEPTH) -> read_address wraps 31->0.
//    gray_read_pointer follows 5'b10000->5'b00000 with no data corruption.
//    Assert rst mid-stream -> all outputs are 0 on the next edge.

Source files
------------

// File: rtl/elastic_read_pointer_control.sv
// Purpose : read side of the RX elastic buffer; syncs the gray write pointer, reads
//           symbols in order, repeats an SKP when occupancy runs low, flags underflow.
// Latency : data_out/data_valid update one read_clk after read_address is presented.
// Backpressure: none toward the writer; the read side only holds its own pointer
//           (FILL or SKP repeat) and never stalls the write side.
//
// Ports:
//   read_clk           read-domain clock
//   rst                synchronous active-high reset
//   gray_write_pointer gray-coded write pointer from the write domain (asynchronous)
//   data_in            buffer memory read data at read_address (combinational read)
//   read_address       binary read pointer, MSB is the wrap bit
//   gray_read_pointer  gray-coded read_address, combinational
//   data_out           registered output symbol
//   data_valid         data_out carries a valid symbol
//   underflow          one-cycle pulse when the buffer is found empty while running
//   Skp_Added          one-cycle pulse when an SKP is repeated
module elastic_read_pointer_control #(
  parameter int DATA_WIDTH    = 10,
  parameter int BUFFER_DEPTH  = 16,
  parameter int LOW_WATERMARK = 4,
  parameter int SYNC_STAGES   = 2,
  localparam int A = $clog2(BUFFER_DEPTH)
) (
  input  logic                  read_clk,
  input  logic                  rst,
  input  logic [A:0]            gray_write_pointer,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [A:0]            read_address,
  output logic [A:0]            gray_read_pointer,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  underflow,
  output logic                  Skp_Added
);

  // The two running-disparity encodings of the SKP code group.
  localparam logic [DATA_WIDTH-1:0] SKP_NEG = DATA_WIDTH'(10'b001111_1001);
  localparam logic [DATA_WIDTH-1:0] SKP_POS = DATA_WIDTH'(10'b110000_0110);

  localparam logic [A:0] HALF_FULL = (A+1)'(BUFFER_DEPTH / 2);
  localparam logic [A:0] LOW_MARK  = (A+1)'(LOW_WATERMARK);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [A:0]            sync_q [SYNC_STAGES];
  logic [A:0]            wr_bin_s;
  logic [A:0]            occ;
  logic                  is_skp;
  logic                  skp_held;

  logic [A:0]            read_address_d;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  data_valid_d;
  logic                  underflow_d;
  logic                  skp_added_d;
  logic                  skp_held_d;

  function automatic logic [A:0] gray2bin(input logic [A:0] g);
    logic [A:0] b;
    b[A] = g[A];
    for (int i = A - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Gray pointer changes one bit per write, so each flop stage sees a clean value
  // (old or new) and the decoded pointer is never ahead of the real write pointer.
  always_ff @(posedge read_clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gray_write_pointer;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wr_bin_s          = gray2bin(sync_q[SYNC_STAGES-1]);
  // Modulo 2^(A+1) subtraction keeps occupancy correct across the wrap bit.
  assign occ               = wr_bin_s - read_address;
  assign gray_read_pointer = read_address ^ (read_address >> 1);
  assign is_skp            = (data_in == SKP_NEG) || (data_in == SKP_POS);

  always_comb begin
    state_d        = state_q;
    read_address_d = read_address;
    data_out_d     = data_out;
    data_valid_d   = 1'b0;
    underflow_d    = 1'b0;
    skp_added_d    = 1'b0;
    skp_held_d     = skp_held;

    unique case (state_q)
      FILL: begin
        if (occ >= HALF_FULL) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (occ == '0) begin
          underflow_d = 1'b1;
          state_d     = FILL;
        end else begin
          data_out_d   = data_in;
          data_valid_d = 1'b1;
          // Hold the pointer on a SKP once so it is emitted twice; skp_held stops
          // the same SKP position from being repeated again on the next cycle.
          if (is_skp && (occ < LOW_MARK) && !skp_held) begin
            skp_added_d = 1'b1;
            skp_held_d  = 1'b1;
          end else begin
            read_address_d = read_address + 1'b1;
            skp_held_d     = 1'b0;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge read_clk) begin
    if (rst) begin
      state_q      <= FILL;
      read_address <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      underflow    <= 1'b0;
      Skp_Added    <= 1'b0;
      skp_held     <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_address <= read_address_d;
      data_out     <= data_out_d;
      data_valid   <= data_valid_d;
      underflow    <= underflow_d;
      Skp_Added    <= skp_added_d;
      skp_held     <= skp_held_d;
    end
  end

endmodule

// File: tb/tb_elastic_read_pointer_control.sv
// Bench for the elastic buffer read side: the bench plays the write side and the
// buffer memory, and compares the DUT against a cycle-level behavioural model plus
// an in-order symbol scoreboard.
module tb_elastic_read_pointer_control;

  localparam int DEPTH = 16;
  localparam int LW    = 4;
  localparam int SS    = 2;
  localparam logic [9:0] SKP_A = 10'b001111_1001;
  localparam logic [9:0] SKP_B = 10'b110000_0110;

  logic       read_clk = 1'b0;
  logic       rst;
  logic [4:0] gray_write_pointer;
  logic [9:0] data_in;
  logic [4:0] read_address;
  logic [4:0] gray_read_pointer;
  logic [9:0] data_out;
  logic       data_valid;
  logic       underflow;
  logic       Skp_Added;

  logic [9:0] mem [DEPTH];
  assign data_in = mem[read_address[3:0]];

  always #5 read_clk = ~read_clk;

  elastic_read_pointer_control #(
    .DATA_WIDTH(10), .BUFFER_DEPTH(DEPTH), .LOW_WATERMARK(LW), .SYNC_STAGES(SS)
  ) dut (
    .read_clk(read_clk),
    .rst(rst),
    .gray_write_pointer(gray_write_pointer),
    .data_in(data_in),
    .read_address(read_address),
    .gray_read_pointer(gray_read_pointer),
    .data_out(data_out),
    .data_valid(data_valid),
    .underflow(underflow),
    .Skp_Added(Skp_Added)
  );

  int checks = 0;
  int errors = 0;

  // write side
  int         wr_ptr;
  logic [9:0] sb [$];

  // behavioural model
  bit         m_run;
  int         m_rd;
  logic [9:0] m_out;
  bit         m_vld, m_unf, m_skp, m_held;
  int         hist [$];

  bit         seen_wrap;
  int         prev_addr;

  int         skp_cnt, unf_cnt, vld_cnt, a_cnt, b_cnt, n;
  logic [9:0] first_sym, d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] r;
    do r = 10'($urandom); while (r == SKP_A || r == SKP_B);
    return r;
  endfunction

  function automatic int fill();
    return (wr_ptr - m_rd + 32) % 32;
  endfunction

  task automatic write_sym(input logic [9:0] v);
    mem[wr_ptr % DEPTH] = v;
    sb.push_back(v);
    wr_ptr = (wr_ptr + 1) % 32;
    gray_write_pointer = 5'(wr_ptr ^ (wr_ptr >> 1));
  endtask

  // One read_clk cycle: predict from pre-edge inputs, clock, then compare.
  task automatic step(input bit do_rst);
    int         occ;
    logic [9:0] head;
    rst  = do_rst;
    occ  = (hist[0] - m_rd + 32) % 32;
    head = mem[m_rd % DEPTH];
    if (do_rst) begin
      m_run = 0; m_rd = 0; m_out = '0; m_vld = 0; m_unf = 0; m_skp = 0; m_held = 0;
      hist.delete();
      repeat (SS) hist.push_back(0);
      sb.delete();
    end else begin
      hist.push_back(wr_ptr);
      void'(hist.pop_front());
      m_vld = 0; m_unf = 0; m_skp = 0;
      if (!m_run) begin
        if (occ >= DEPTH / 2) m_run = 1;
      end else if (occ == 0) begin
        m_unf = 1;
        m_run = 0;
      end else begin
        m_out = head;
        m_vld = 1;
        if ((head == SKP_A || head == SKP_B) && occ < LW && !m_held) begin
          m_skp  = 1;
          m_held = 1;
        end else begin
          m_rd   = (m_rd + 1) % 32;
          m_held = 0;
        end
      end
    end
    @(posedge read_clk);
    #1;
    chk("read_address", read_address, m_rd);
    chk("gray_read_pointer", gray_read_pointer, m_rd ^ (m_rd >> 1));
    chk("data_out", data_out, m_out);
    chk("data_valid", data_valid, m_vld);
    chk("underflow", underflow, m_unf);
    chk("Skp_Added", Skp_Added, m_skp);
    if (!do_rst && m_vld) begin
      if (sb.size() > 0) begin
        chk("order", data_out, sb[0]);
        if (!m_skp) void'(sb.pop_front());
      end else begin
        chk("order_nonempty", 32'(sb.size()), 1);
      end
    end
    if (prev_addr == 31 && read_address == 5'd0) seen_wrap = 1;
    prev_addr = int'(read_address);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    wr_ptr = 0;
    gray_write_pointer = '0;
    rst = 1'b1;
    seen_wrap = 0;
    prev_addr = 0;
    hist.delete();
    repeat (SS) hist.push_back(0);

    step(1);
    step(1);
    chk("rst_addr", read_address, 0);
    chk("rst_gray", gray_read_pointer, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_skp", Skp_Added, 0);

    // 1: fill 8 entries; RUN after SS+1 cycles, first valid symbol one cycle later
    first_sym = rand_data();
    write_sym(first_sym);
    repeat (7) write_sym(rand_data());
    step(0); step(0); step(0);
    chk("fill_no_valid", data_valid, 0);
    step(0);
    chk("first_valid", data_valid, 1);
    chk("first_data", data_out, first_sym);

    // 2: steady stream, occupancy around 8
    repeat (3) write_sym(rand_data());
    skp_cnt = 0; unf_cnt = 0; vld_cnt = 0;
    repeat (20) begin
      write_sym(rand_data());
      step(0);
      skp_cnt += int'(Skp_Added);
      unf_cnt += int'(underflow);
      vld_cnt += int'(data_valid);
    end
    chk("steady_skp", skp_cnt, 0);
    chk("steady_unf", unf_cnt, 0);
    chk("steady_valid", vld_cnt, 20);

    // 3/4/5: SKP_B read at occ 6 (no repeat), SKP_A at occ 3 (repeat), then empty
    skp_cnt = 0; unf_cnt = 0; a_cnt = 0; b_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      d = (k == 0) ? SKP_B : (k == 3) ? SKP_A : rand_data();
      write_sym(d);
      step(0);
      skp_cnt += int'(Skp_Added);
      a_cnt   += int'(data_valid && data_out == SKP_A);
      b_cnt   += int'(data_valid && data_out == SKP_B);
    end
    n = 0;
    while (!underflow && n < 40) begin
      step(0);
      n++;
      skp_cnt += int'(Skp_Added);
      unf_cnt += int'(underflow);
      a_cnt   += int'(data_valid && data_out == SKP_A);
      b_cnt   += int'(data_valid && data_out == SKP_B);
    end
    chk("drain_underflow", underflow, 1);
    chk("drain_unf_count", unf_cnt, 1);
    chk("unf_valid", data_valid, 0);
    chk("skp_pulses", skp_cnt, 1);
    chk("skp_a_twice", a_cnt, 2);
    chk("skp_b_once", b_cnt, 1);
    step(0);
    chk("unf_one_cycle", underflow, 0);

    // refill: output resumes only after occupancy reaches 8 again
    n = 0;
    do begin
      write_sym(rand_data());
      step(0);
      n++;
    end while (!data_valid && n < 40);
    chk("refill_resumes", data_valid, 1);

    // 6: long stream across the pointer wrap, then random traffic with SKPs
    repeat (40) begin
      if (fill() < 15) write_sym(rand_data());
      step(0);
    end
    repeat (200) begin
      if ($urandom_range(0, 3) != 0 && fill() < 15)
        write_sym(($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? SKP_A : SKP_B)
                                              : rand_data());
      step(0);
    end
    chk("wrap_seen", seen_wrap, 1);

    // reset in the middle of the stream
    if (fill() < 15) write_sym(rand_data());
    step(1);
    chk("midrst_addr", read_address, 0);
    chk("midrst_gray", gray_read_pointer, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_valid", data_valid, 0);
    chk("midrst_unf", underflow, 0);
    chk("midrst_skp", Skp_Added, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
